// File: rtl/bitmanip_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : bitmanip_pkg
//  Brief   : Shared constants and state encoding for the grev issue/capture
//            sequencer.
//  Rev     : 1.0  initial release
// ============================================================================
package bitmanip_pkg;

  localparam int XLEN          = 32;
  localparam int SHAMT_W       = 5;
  localparam int TAG_W         = 5;
  localparam int GREV_CORE_LAT = 6;

  // Run counter: counts 1..GREV_CORE_LAT+1, so 3 bits cover latency 6.
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(GREV_CORE_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(GREV_CORE_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/grev_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : grev_issue_ctrl
//  Brief   : Issue/capture sequencer in front of the iterative 32-bit
//            generalized-reverse core. Launches the core with a one-cycle
//            start, checks its fixed latency, and holds the result under a
//            valid/ready handshake.
//  Config  : GREV_ZERO_BYPASS_EN - when defined, ops with rs2==0 skip the
//            core and return rs1 with one-cycle latency.
//  Rev     : 1.0  initial release
// ============================================================================
module grev_issue_ctrl
  import bitmanip_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [SHAMT_W-1:0] in_rs2,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_rd,
  output logic [TAG_W-1:0]   out_tag,
  output logic               err,
  output logic               core_start,
  output logic [XLEN-1:0]    core_rs1,
  output logic [SHAMT_W-1:0] core_rs2,
  input  logic [XLEN-1:0]    core_rd,
  input  logic               core_done
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [TAG_W-1:0]   tag_q;
  logic               fire;
  logic               bypass;
  logic               capture;
  logic               bad_timing;

  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign fire      = in_valid && in_ready;
  assign out_valid = (state == HOLD);

`ifdef GREV_ZERO_BYPASS_EN
  assign bypass = (in_rs2 == '0);
`else
  assign bypass = 1'b0;
`endif

  // The core has no reset, so it only ever sees a start for ops it must compute.
  assign core_start = fire && !bypass;
  assign core_rs1   = in_rs1;
  assign core_rs2   = in_rs2;

  // Leave RUN on any done or at timeout; anything but done at the expected
  // count is a timing fault of the core.
  assign capture    = (state == RUN) && (core_done || (cnt == CNT_MAX));
  assign bad_timing = (state == RUN) &&
                      (core_done ? (cnt != CNT_DONE) : (cnt == CNT_MAX));

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state selection; a fire from IDLE or HOLD goes to RUN or, when
  // bypassed, straight back to HOLD.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (fire) state_nxt = bypass ? HOLD : RUN;
      RUN:  if (capture) state_nxt = HOLD;
      HOLD: begin
        if (out_ready) begin
          if (fire) state_nxt = bypass ? HOLD : RUN;
          else      state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latency counter: 1 in the first RUN cycle, saturating at CNT_MAX.
  always_ff @(posedge clock) begin
    if (!resetn)                                  cnt <= '0;
    else if (core_start)                          cnt <= CNT_W'(1);
    else if ((state == RUN) && (cnt != CNT_MAX))  cnt <= cnt + CNT_W'(1);
  end

  // Request tag travels alongside the op while the core is busy.
  always_ff @(posedge clock) begin
    if (fire) tag_q <= in_tag;
  end

  // Result register: no reset needed, only meaningful while out_valid.
  always_ff @(posedge clock) begin
    if (fire && bypass) begin
      out_rd  <= in_rs1;
      out_tag <= in_tag;
    end else if (capture) begin
      out_rd  <= core_rd;
      out_tag <= tag_q;
    end
  end

  // Sticky timing-fault flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (!resetn)         err <= 1'b0;
    else if (bad_timing) err <= 1'b1;
  end

endmodule
`default_nettype wire
